// File: rtl/stack_sequencer.sv
// stack_sequencer: walks a push/pop register bitmask one stack slot at a time.
// For every selected slot it issues one word bus cycle and the matching
// register-file access, and it produces the updated SP once the mask is exhausted.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start, i_pop          begin a sequence (sampled in IDLE only); 0 = push, 1 = pop
//   i_mask, i_sp_in         slot bitmask and entry SP, latched with i_start
//   o_busy, o_done          sequence in progress / one-cycle completion pulse
//   o_sp_out, o_sp_we       final SP, written when o_done
//   o_reg_sel, i_reg_rdata  addressed register slot and its combinational read data
//   o_reg_we, o_reg_wdata   register write strobe and data (pop only)
//   o_bus_req, o_bus_write, o_bus_addr, o_bus_wdata   word bus request
//   i_bus_rdata, i_bus_ack  pop data and bus cycle completion
module stack_sequencer #(
    parameter int                MASK_W    = 16,
    parameter int                SEL_W     = $clog2(MASK_W),
    parameter int                SP_BIT    = 4,
    parameter logic [MASK_W-1:0] SKIP_MASK = 'h0020
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_pop,
    input  logic [MASK_W-1:0] i_mask,
    input  logic [15:0]       i_sp_in,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_sp_out,
    output logic              o_sp_we,
    output logic [SEL_W-1:0]  o_reg_sel,
    input  logic [15:0]       i_reg_rdata,
    output logic              o_reg_we,
    output logic [15:0]       o_reg_wdata,
    output logic              o_bus_req,
    output logic              o_bus_write,
    output logic [15:0]       o_bus_addr,
    output logic [15:0]       o_bus_wdata,
    input  logic [15:0]       i_bus_rdata,
    input  logic              i_bus_ack
);

    typedef enum logic [1:0] {StIdle, StScan, StBus, StDone} state_e;

    state_e            r_state;
    logic [MASK_W-1:0] r_work;
    logic              r_pop;
    logic [15:0]       r_sp_work;
    logic [15:0]       r_sp_entry;
    logic [SEL_W-1:0]  r_sel;
    logic              r_bus_req;
    logic              r_bus_write;
    logic [15:0]       r_bus_addr;
    logic [15:0]       r_bus_wdata;

    logic [SEL_W-1:0]  w_sel;
    logic [MASK_W-1:0] w_onehot;
    logic              w_is_skip;
    logic              w_work_empty;
    logic              w_rest_empty;
    logic              w_reg_we;
    logic [15:0]       w_sp_inc;
    logic [15:0]       w_sp_dec;

    // Push walks lowest-first, pop highest-first, so a pop unwinds a push in reverse.
    always_comb begin
        w_sel = '0;
        if (r_pop) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (r_work[i]) w_sel = SEL_W'(i);
            end
        end else begin
            for (int i = MASK_W - 1; i >= 0; i--) begin
                if (r_work[i]) w_sel = SEL_W'(i);
            end
        end
    end

    // r_work is unchanged while in BUS, so w_onehot still names the slot in flight.
    assign w_onehot     = {{(MASK_W-1){1'b0}}, 1'b1} << w_sel;
    assign w_is_skip    = |(w_onehot & SKIP_MASK);
    assign w_work_empty = (r_work == '0);
    assign w_rest_empty = ((r_work & ~w_onehot) == '0);
    assign w_sp_inc     = r_sp_work + 16'd2;
    assign w_sp_dec     = r_sp_work - 16'd2;
    assign w_reg_we     = (r_state == StBus) && r_pop && i_bus_ack;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_work      <= '0;
            r_pop       <= 1'b0;
            r_sp_work   <= '0;
            r_sp_entry  <= '0;
            r_sel       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_work     <= i_mask;
                        r_pop      <= i_pop;
                        r_sp_work  <= i_sp_in;
                        r_sp_entry <= i_sp_in;
                        r_state    <= StScan;
                    end
                end
                StScan: begin
                    if (w_work_empty) begin
                        r_state <= StDone;
                    end else if (w_is_skip) begin
                        // Skipped slots still occupy stack space on pop, never on push.
                        r_work <= r_work & ~w_onehot;
                        if (r_pop) r_sp_work <= w_sp_inc;
                    end else begin
                        r_sel       <= w_sel;
                        r_bus_req   <= 1'b1;
                        r_bus_write <= ~r_pop;
                        if (r_pop) begin
                            r_bus_addr  <= r_sp_work;
                            r_bus_wdata <= '0;
                        end else begin
                            r_sp_work   <= w_sp_dec;
                            r_bus_addr  <= w_sp_dec;
                            // The SP slot pushes the entry SP, not the live register.
                            r_bus_wdata <= (w_sel == SEL_W'(SP_BIT)) ? r_sp_entry : i_reg_rdata;
                        end
                        r_state <= StBus;
                    end
                end
                StBus: begin
                    if (i_bus_ack) begin
                        if (r_pop) r_sp_work <= w_sp_inc;
                        r_work      <= r_work & ~w_onehot;
                        r_bus_req   <= 1'b0;
                        r_bus_write <= 1'b0;
                        // Nothing left to walk: skip the empty SCAN visit.
                        r_state     <= w_rest_empty ? StDone : StScan;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // reg_sel must be live during SCAN so i_reg_rdata can be captured that cycle.
    assign o_reg_sel   = (r_state == StScan) ? w_sel : r_sel;
    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StDone);
    assign o_sp_we     = o_done;
    assign o_sp_out    = o_done ? r_sp_work : 16'd0;
    assign o_reg_we    = w_reg_we;
    assign o_reg_wdata = w_reg_we ? i_bus_rdata : 16'd0;
    assign o_bus_req   = r_bus_req;
    assign o_bus_write = r_bus_write;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  sel;
        int          len;
    } op_t;

    logic        clk = 1'b0;
    logic        reset, start, pop, bus_ack;
    logic [15:0] mask, sp_in, reg_rdata, bus_rdata;
    logic        busy, done, sp_we, reg_we, bus_req, bus_write;
    logic [15:0] sp_out, reg_wdata, bus_addr, bus_wdata;
    logic [3:0]  reg_sel;

    logic [15:0] regfile [16];
    assign reg_rdata = regfile[reg_sel];

    stack_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_pop(pop), .i_mask(mask),
        .i_sp_in(sp_in), .o_busy(busy), .o_done(done), .o_sp_out(sp_out), .o_sp_we(sp_we),
        .o_reg_sel(reg_sel), .i_reg_rdata(reg_rdata), .o_reg_we(reg_we),
        .o_reg_wdata(reg_wdata), .o_bus_req(bus_req), .o_bus_write(bus_write),
        .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .i_bus_rdata(bus_rdata),
        .i_bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference expectations
    op_t exp_q[$];
    int  exp_done;
    logic [15:0] exp_sp;

    // Observations from the last sequence
    op_t obs_q[$];
    logic [15:0] rd_q[$];
    logic [19:0] we_q[$];
    int obs_done, obs_first_req, timeout, post_busy, unstable, sp_we_seen;
    logic [15:0] obs_sp;

    // Slot walk from the rules: order, SP arithmetic, data choice, cycle cost.
    task automatic model(input logic p, input logic [15:0] m, input logic [15:0] s0, input int dly);
        logic [15:0] s;
        int t;
        bit last_xfer;
        op_t o;
        exp_q.delete();
        s = s0; t = 1; last_xfer = 0;
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = p ? 15 - k : k;
            if (m[idx]) begin
                if (idx == 5) begin
                    if (p) s = s + 16'd2;
                    t += 1;
                    last_xfer = 0;
                end else begin
                    o.wr = !p; o.sel = idx[3:0]; o.len = dly + 1;
                    if (p) begin
                        o.addr = s; o.data = '0; s = s + 16'd2;
                    end else begin
                        s = s - 16'd2; o.addr = s; o.data = (idx == 4) ? s0 : regfile[idx];
                    end
                    exp_q.push_back(o);
                    t += 2 + dly;
                    last_xfer = 1;
                end
            end
        end
        exp_done = last_xfer ? t : t + 1;
        exp_sp = s;
    endtask

    // Drives one sequence and acts as the bus slave; records what it sees.
    task automatic run_seq(input logic p, input logic [15:0] m, input logic [15:0] s,
                           input int dly, input bit extra, input bit noise);
        int cyc, age;
        bit prev_req;
        op_t o;
        obs_q.delete(); rd_q.delete(); we_q.delete();
        obs_done = -1; obs_first_req = -1; timeout = 0; post_busy = 0; unstable = 0;
        sp_we_seen = 0; obs_sp = '0;
        o.wr = 0; o.addr = '0; o.data = '0; o.sel = '0; o.len = 0;
        @(negedge clk);
        start = 1; pop = p; mask = m; sp_in = s;
        cyc = 0; age = 0; prev_req = 0;
        forever begin
            @(negedge clk);
            cyc++;
            start = extra && (cyc <= 2);
            if (extra) mask = 16'hFFFF;
            bus_ack = 0;
            if (bus_req) begin
                if (!prev_req) begin
                    o.wr = bus_write; o.addr = bus_addr; o.data = bus_wdata; o.sel = reg_sel;
                    o.len = 0; age = 0;
                    if (obs_first_req < 0) obs_first_req = cyc;
                    bus_rdata = 16'($urandom);
                    rd_q.push_back(bus_rdata);
                end else if (bus_write !== o.wr || bus_addr !== o.addr || bus_wdata !== o.data
                             || reg_sel !== o.sel) begin
                    unstable++;
                end
                o.len++;
                if (age == dly) bus_ack = 1;
                age++;
            end else begin
                if (prev_req) obs_q.push_back(o);
                if (noise) bus_ack = 1'($urandom_range(0, 1));
            end
            prev_req = bus_req;
            #1;
            if (reg_we) we_q.push_back({reg_sel, reg_wdata});
            if (done) begin
                obs_done = cyc; obs_sp = sp_out; sp_we_seen = sp_we;
                break;
            end
            if (cyc > 300) begin
                timeout = 1;
                break;
            end
        end
        @(negedge clk);
        start = 0; bus_ack = 0; post_busy = busy;
        @(negedge clk);
        post_busy = post_busy | busy;
    endtask

    task automatic test_reset;
        reset = 1; start = 1; pop = 0; mask = 16'hFFFF; sp_in = 16'h1234;
        bus_ack = 1; bus_rdata = 16'hBEEF;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sp_we, reg_we, bus_req, bus_write, sp_out, reg_sel, reg_wdata,
             bus_addr, bus_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b req=%b addr=%h sel=%h got nonzero, want all 0",
                     busy, done, bus_req, bus_addr, reg_sel);
        end
        reset = 0; start = 0; bus_ack = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_push_frame;
        for (int i = 0; i < 16; i++) regfile[i] = 16'($urandom);
        model(0, 16'h01DF, 16'h1000, 0);
        run_seq(0, 16'h01DF, 16'h1000, 0, 0, 0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL push_op_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i].wr !== 1'b1 || obs_q[i].addr !== exp_q[i].addr ||
                    obs_q[i].sel !== exp_q[i].sel || obs_q[i].data !== exp_q[i].data ||
                    obs_q[i].len != 1) begin
                    errors++;
                    $display("FAIL push_op%0d: got wr=%b sel=%0d %h@%h len=%0d want sel=%0d %h@%h",
                             i, obs_q[i].wr, obs_q[i].sel, obs_q[i].data, obs_q[i].addr,
                             obs_q[i].len, exp_q[i].sel, exp_q[i].data, exp_q[i].addr);
                end
            end
        end
        checks++;
        if (obs_q.size() > 4 && obs_q[4].data !== 16'h1000) begin
            errors++;
            $display("FAIL push_sp_slot_data: got %h want 1000", obs_q[4].data);
        end
        checks++;
        if (obs_done != 17 || obs_done != exp_done) begin
            errors++;
            $display("FAIL push_done_cycle: got %0d want %0d", obs_done, exp_done);
        end
        checks++;
        if (obs_sp !== 16'h0FF0 || sp_we_seen !== 1) begin
            errors++;
            $display("FAIL push_sp_out: got %h we=%0d want 0ff0 we=1", obs_sp, sp_we_seen);
        end
        checks++;
        if (obs_first_req != 2 || we_q.size() != 0 || unstable != 0) begin
            errors++;
            $display("FAIL push_timing: got first_req=%0d reg_we=%0d unstable=%0d want 2 0 0",
                     obs_first_req, we_q.size(), unstable);
        end
    endtask

    task automatic test_pop_frame;
        model(1, 16'h01EF, 16'h0FF0, 0);
        run_seq(1, 16'h01EF, 16'h0FF0, 0, 0, 0);
        checks++;
        if (obs_q.size() != 7 || exp_q.size() != 7) begin
            errors++;
            $display("FAIL pop_op_count: got %0d want 7", obs_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (obs_q[i].wr !== 1'b0 || obs_q[i].addr !== exp_q[i].addr ||
                    obs_q[i].sel !== exp_q[i].sel || obs_q[i].addr === 16'h0FF6) begin
                    errors++;
                    $display("FAIL pop_op%0d: got wr=%b sel=%0d @%h want sel=%0d @%h", i,
                             obs_q[i].wr, obs_q[i].sel, obs_q[i].addr, exp_q[i].sel, exp_q[i].addr);
                end
            end
        end
        checks++;
        if (we_q.size() != 7) begin
            errors++;
            $display("FAIL pop_reg_we_count: got %0d want 7", we_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (we_q[i] !== {exp_q[i].sel, rd_q[i]}) begin
                    errors++;
                    $display("FAIL pop_reg_write%0d: got %h want %h", i, we_q[i],
                             {exp_q[i].sel, rd_q[i]});
                end
            end
        end
        checks++;
        if (obs_done != 16 || obs_done != exp_done || obs_sp !== 16'h1000) begin
            errors++;
            $display("FAIL pop_done: got cycle %0d sp %h want cycle 16 sp 1000", obs_done, obs_sp);
        end
    endtask

    task automatic test_wait_states;
        for (int i = 0; i < 16; i++) regfile[i] = 16'($urandom);
        model(0, 16'h0800, 16'h0000, 3);
        run_seq(0, 16'h0800, 16'h0000, 3, 0, 0);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].addr !== 16'hFFFE || obs_q[0].len != 4 ||
            obs_q[0].data !== regfile[11] || unstable != 0) begin
            errors++;
            $display("FAIL wait_op: got n=%0d addr=%h len=%0d unstable=%0d want 1 fffe 4 0",
                     obs_q.size(), obs_q.size() ? obs_q[0].addr : 16'h0,
                     obs_q.size() ? obs_q[0].len : 0, unstable);
        end
        checks++;
        if (obs_sp !== 16'hFFFE || obs_done != exp_done) begin
            errors++;
            $display("FAIL wait_done: got sp %h cycle %0d want fffe cycle %0d",
                     obs_sp, obs_done, exp_done);
        end
    endtask

    task automatic test_empty_and_busy_start;
        logic [15:0] s;
        s = 16'($urandom);
        run_seq(0, 16'h0000, s, 0, 1, 0);
        checks++;
        if (obs_done != 2 || obs_sp !== s || obs_q.size() != 0 || obs_first_req != -1) begin
            errors++;
            $display("FAIL empty_mask: got cycle %0d sp %h reqs %0d want cycle 2 sp %h reqs 0",
                     obs_done, obs_sp, obs_q.size(), s);
        end
        checks++;
        if (post_busy != 0) begin
            errors++;
            $display("FAIL start_while_busy: got busy after done %0d want 0", post_busy);
        end
    endtask

    task automatic test_skip_push;
        logic [15:0] s;
        s = 16'($urandom);
        model(0, 16'h0020, s, 0);
        run_seq(0, 16'h0020, s, 0, 0, 0);
        checks++;
        if (obs_q.size() != 0 || obs_sp !== s || obs_done != exp_done) begin
            errors++;
            $display("FAIL skip_push: got reqs %0d sp %h cycle %0d want 0 %h %0d",
                     obs_q.size(), obs_sp, obs_done, s, exp_done);
        end
    endtask

    task automatic test_reset_mid_bus;
        int bad;
        @(negedge clk);
        start = 1; pop = 0; mask = 16'h000F; sp_in = 16'h2000; bus_ack = 0;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL midbus_req_before_reset: got %b want 1", bus_req);
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if ({busy, done, sp_we, reg_we, bus_req, bus_write, sp_out, reg_sel, reg_wdata,
             bus_addr, bus_wdata} !== '0) begin
            errors++;
            $display("FAIL midbus_reset_outputs: busy=%b req=%b addr=%h data=%h want all 0",
                     busy, bus_req, bus_addr, bus_wdata);
        end
        reset = 0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || bus_req || busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midbus_no_resume: got %0d active cycles want 0", bad);
        end
        model(0, 16'h000F, 16'h2000, 0);
        run_seq(0, 16'h000F, 16'h2000, 0, 0, 0);
        checks++;
        if (obs_q.size() != 4 || obs_sp !== exp_sp || obs_done != exp_done) begin
            errors++;
            $display("FAIL midbus_fresh_run: got reqs %0d sp %h cycle %0d want 4 %h %0d",
                     obs_q.size(), obs_sp, obs_done, exp_sp, exp_done);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 25; it++) begin
            logic p;
            logic [15:0] m, s;
            int d;
            p = 1'($urandom_range(0, 1));
            m = 16'($urandom);
            s = 16'($urandom);
            d = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++) regfile[i] = 16'($urandom);
            model(p, m, s, d);
            run_seq(p, m, s, d, 0, 1);
            checks++;
            if (timeout || obs_done != exp_done || obs_sp !== exp_sp || unstable != 0) begin
                errors++;
                $display("FAIL rand%0d_done: got cycle %0d sp %h unstable %0d want cycle %0d sp %h",
                         it, obs_done, obs_sp, unstable, exp_done, exp_sp);
            end
            checks++;
            if (obs_q.size() != exp_q.size() || we_q.size() != (p ? exp_q.size() : 0)) begin
                errors++;
                $display("FAIL rand%0d_counts: got ops %0d we %0d want ops %0d", it,
                         obs_q.size(), we_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (obs_q[i].wr !== exp_q[i].wr || obs_q[i].addr !== exp_q[i].addr ||
                        obs_q[i].sel !== exp_q[i].sel || obs_q[i].len != exp_q[i].len ||
                        (!p && obs_q[i].data !== exp_q[i].data) ||
                        (p && we_q[i] !== {exp_q[i].sel, rd_q[i]})) begin
                        errors++;
                        $display("FAIL rand%0d_op%0d: got sel=%0d %h@%h len=%0d want sel=%0d %h@%h len=%0d",
                                 it, i, obs_q[i].sel, obs_q[i].data, obs_q[i].addr, obs_q[i].len,
                                 exp_q[i].sel, exp_q[i].data, exp_q[i].addr, exp_q[i].len);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_frame();
        test_pop_frame();
        test_wait_states();
        test_empty_and_busy_start();
        test_skip_push();
        test_reset_mid_bus();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
